// File: rtl/dcpu16_mbox_slv.sv
// dcpu16_mbox_slv: Wishbone-classic mailbox responder on the dcpu16 data bus.
// Ports: clk/rst (async active-low) | ab_adr, ab_dto, ab_stb, ab_wre in; ab_dti, ab_ack out (CPU side)
//        mb_dat, mb_vld out, mb_rdy in (TX consumer) | mi_dat, mi_vld in, mi_rdy out (RX producer)
// Window: STATUS(+0), TXDATA(+1), RXDATA(+2), SCRATCH(+3); WAIT wait states then a one-cycle ack.
module dcpu16_mbox_slv #(
  parameter logic [15:0] BASE     = 16'hFFF0,
  parameter int          WAIT     = 0,
  parameter int          DEPTH_LG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ab_adr,
  input  logic [15:0] ab_dto,
  output logic [15:0] ab_dti,
  input  logic        ab_stb,
  input  logic        ab_wre,
  output logic        ab_ack,
  output logic [15:0] mb_dat,
  output logic        mb_vld,
  input  logic        mb_rdy,
  input  logic [15:0] mi_dat,
  input  logic        mi_vld,
  output logic        mi_rdy
);
  localparam int                DEPTH = 1 << DEPTH_LG;
  localparam logic [DEPTH_LG:0] FULL  = {1'b1, {DEPTH_LG{1'b0}}};
  localparam logic [DEPTH_LG:0] CONE  = (DEPTH_LG + 1)'(1);
  localparam logic [DEPTH_LG-1:0] PONE = DEPTH_LG'(1);
  typedef enum logic [1:0] {IDLE, WT, ACK} state_t;
  state_t              r_st;
  logic [3:0]          r_cnt;
  logic [1:0]          r_off;
  logic                r_wre;
  logic [15:0]         r_dto;
  logic                r_rx_hit;
  logic                r_ack;
  logic [15:0]         r_dti;
  logic [15:0]         r_scr;
  logic                r_tx_ovf;
  logic                r_rx_udf;
  logic [15:0]         r_tx_mem [DEPTH];
  logic [15:0]         r_rx_mem [DEPTH];
  logic [DEPTH_LG-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [DEPTH_LG:0]   r_tx_cnt, r_rx_cnt;
  logic        w_sel, w_go_ack, w_commit, w_wre;
  logic [1:0]  w_off;
  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic        w_tx_pop, w_tx_req, w_tx_push, w_rx_pop, w_rx_push, w_stat_wr;
  logic [15:0] w_status, w_rdat;
  assign w_sel      = ab_stb && (ab_adr[15:2] == BASE[15:2]);
  assign w_commit   = (r_st == ACK);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL);
  assign w_tx_pop   = !w_tx_empty && mb_rdy;
  assign w_tx_req   = w_commit && r_wre && (r_off == 2'd1);
  // A full FIFO still takes a push when its head leaves on the same edge
  assign w_tx_push  = w_tx_req && (!w_tx_full || w_tx_pop);
  // Pop only if the head existed when the read data was captured, so data and pop agree
  assign w_rx_pop   = w_commit && !r_wre && (r_off == 2'd2) && r_rx_hit;
  assign mi_rdy     = !w_rx_full || w_rx_pop;
  assign w_rx_push  = mi_vld && mi_rdy;
  assign w_stat_wr  = w_commit && r_wre && (r_off == 2'd0);
  assign w_go_ack   = ((r_st == IDLE) && w_sel && (WAIT == 0)) || ((r_st == WT) && ab_stb && (r_cnt == 4'd0));
  // Entering ACK straight from IDLE uses the live bus; otherwise the latched access
  assign w_off      = (r_st == IDLE) ? ab_adr[1:0] : r_off;
  assign w_wre      = (r_st == IDLE) ? ab_wre : r_wre;
  assign w_status   = {4'(r_rx_cnt), 4'(r_tx_cnt), 2'b00, r_rx_udf, r_tx_ovf,
                       w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
  assign w_rdat     = w_wre ? 16'h0000 :
                      (w_off == 2'd0) ? w_status :
                      (w_off == 2'd1) ? {12'd0, 4'(r_tx_cnt)} :
                      (w_off == 2'd2) ? (w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rp]) : r_scr;
  assign ab_ack     = r_ack;
  assign ab_dti     = r_dti;
  assign mb_vld     = !w_tx_empty;
  assign mb_dat     = r_tx_mem[r_tx_rp];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st     <= IDLE;
      r_cnt    <= '0;
      r_off    <= '0;
      r_wre    <= 1'b0;
      r_dto    <= '0;
      r_rx_hit <= 1'b0;
      r_ack    <= 1'b0;
      r_dti    <= '0;
      r_scr    <= '0;
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      r_ack <= w_go_ack;
      r_dti <= w_go_ack ? w_rdat : 16'h0000;
      if (w_go_ack) r_rx_hit <= !w_rx_empty;
      if (r_st == IDLE && w_sel) begin
        r_off <= ab_adr[1:0];
        r_wre <= ab_wre;
        r_dto <= ab_dto;
        r_cnt <= 4'(WAIT - 1);
        r_st  <= (WAIT == 0) ? ACK : WT;
      end else if (r_st == WT) begin
        r_st  <= !ab_stb ? IDLE : (r_cnt == 4'd0) ? ACK : WT;
        r_cnt <= r_cnt - 4'd1;
      end else if (r_st == ACK) begin
        r_st <= IDLE;
      end
      if (w_commit && r_wre && r_off == 2'd3) r_scr <= r_dto;
      // A new event outranks a clear in the same cycle
      r_tx_ovf <= (w_tx_req && w_tx_full && !w_tx_pop) || (r_tx_ovf && !(w_stat_wr && r_dto[4]));
      r_rx_udf <= (w_commit && !r_wre && r_off == 2'd2 && !r_rx_hit) || (r_rx_udf && !(w_stat_wr && r_dto[5]));
      if (w_tx_push) r_tx_wp <= r_tx_wp + PONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PONE;
      if (w_rx_push) r_rx_wp <= r_rx_wp + PONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PONE;
      r_tx_cnt <= (w_tx_push && !w_tx_pop) ? r_tx_cnt + CONE : (!w_tx_push && w_tx_pop) ? r_tx_cnt - CONE : r_tx_cnt;
      r_rx_cnt <= (w_rx_push && !w_rx_pop) ? r_rx_cnt + CONE : (!w_rx_push && w_rx_pop) ? r_rx_cnt - CONE : r_rx_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= r_dto;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= mi_dat;
  end
endmodule
